// File: rtl/rr_arb_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux_if
// Description : Channel/output handshake bundle for rr_arb_mux.
//               The master modport drives the inputs and the slave modport is the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic                 mode;
    logic [SW-1:0]        sel;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_chan;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb_mux
// Description : N-channel mux with directed or round-robin arbitration feeding
//               a single registered output stage with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           clrn,
    rr_arb_mux_if.slave    bus
);
    localparam int              SW         = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0]   c_last_idx = SW'(N - 1);
    localparam logic [SW:0]     c_n        = (SW + 1)'(N);
    localparam logic [SW-1:0]   c_one      = SW'(1);

    logic [WIDTH-1:0]   w_chan_data [N];
    logic               w_dir_ok;
    logic               w_rr_ok;
    logic [SW-1:0]      w_rr_idx;
    logic [SW:0]        w_idx;
    logic               w_grant_ok;
    logic [SW-1:0]      w_grant;
    logic               w_load;
    logic               w_accept;
    logic [N-1:0]       w_ready;

    logic [WIDTH-1:0]   r_out_data;
    logic [SW-1:0]      r_out_chan;
    logic               r_out_valid;
    logic [SW-1:0]      r_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign w_chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Out-of-range select indices never grant, even when N is not a power of two.
    always_comb begin
        w_dir_ok = 1'b0;
        if (32'(bus.sel) < N) begin
            w_dir_ok = bus.in_valid[bus.sel];
        end
    end

    // Search ptr, ptr+1, ... modulo N; first valid channel wins.
    always_comb begin
        w_rr_ok  = 1'b0;
        w_rr_idx = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (SW + 1)'(k);
            if (w_idx >= c_n) begin
                w_idx = w_idx - c_n;
            end
            if (!w_rr_ok && bus.in_valid[w_idx[SW-1:0]]) begin
                w_rr_ok  = 1'b1;
                w_rr_idx = w_idx[SW-1:0];
            end
        end
    end

    assign w_grant_ok = bus.mode ? w_rr_ok  : w_dir_ok;
    assign w_grant    = bus.mode ? w_rr_idx : bus.sel;
    assign w_load     = ~r_out_valid | bus.out_ready;
    // Gating with clrn keeps in_ready low for the whole reset window.
    assign w_accept   = w_load & w_grant_ok & clrn;

    always_comb begin
        w_ready = '0;
        if (w_accept) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_grant_ok) begin
                r_out_data  <= w_chan_data[w_grant];
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // The served channel becomes lowest priority on the next search.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ptr <= '0;
        end else if (w_load && w_grant_ok && bus.mode) begin
            r_ptr <= (w_grant == c_last_idx) ? '0 : w_grant + c_one;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire
